// File: rtl/seq_alu_pkg.sv
// Shared types and 7-segment constants for the sequential ALU with display output.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_ACC = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [7:0] BLANK     = 8'h00;
  localparam logic [7:0] DASH      = 8'h40;
  localparam int         MINUS_BIT = 7;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'h0: digit_seg = SEG_0;
      4'h1: digit_seg = SEG_1;
      4'h2: digit_seg = SEG_2;
      4'h3: digit_seg = SEG_3;
      4'h4: digit_seg = SEG_4;
      4'h5: digit_seg = SEG_5;
      4'h6: digit_seg = SEG_6;
      4'h7: digit_seg = SEG_7;
      4'h8: digit_seg = SEG_8;
      4'h9: digit_seg = SEG_9;
      4'hA: digit_seg = SEG_A;
      4'hB: digit_seg = SEG_B;
      4'hC: digit_seg = SEG_C;
      4'hD: digit_seg = SEG_D;
      4'hE: digit_seg = SEG_E;
      default: digit_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_7seg_seg7_enc.sv
// Combinational display encoder: overflow blanks, small magnitudes show a signed hex digit,
// anything else shows a dash.
module seg7_enc
  import seq_alu_pkg::*;
(
  input  logic [3:0] mag,
  input  logic       neg,
  input  logic       fits,
  input  logic       ovf,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    seg = DASH;
    if (ovf) begin
      seg = BLANK;
    end else if (fits) begin
      seg            = {1'b0, digit_seg(mag)};
      seg[MINUS_BIT] = neg;
    end
  end

endmodule

// File: rtl/seq_alu_7seg.sv
// Sequential signed ALU (add/sub/and/or/iterative multiply/accumulate) with a registered
// 7-segment rendering of each result.
module seq_alu_7seg
  import seq_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             ovf,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       seg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] mcand, prod;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   add_y, sub_y, acc_y, mul_y, fin_y, fin_mag, mag_a, mag_b;
  logic               add_ovf, sub_ovf, acc_ovf, mul_ovf, fin_ovf;
  logic [2*WIDTH-1:0] prod_next, prod_signed;
  logic [16:0]        mag_ext;
  logic [7:0]         seg_next;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign add_y   = a_q + b_q;
  assign sub_y   = a_q - b_q;
  assign acc_y   = acc + a_q;
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_y[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_y[WIDTH-1] != a_q[WIDTH-1]);
  assign acc_ovf = (acc[WIDTH-1] == a_q[WIDTH-1]) && (acc_y[WIDTH-1] != acc[WIDTH-1]);

  // Shift-add runs on magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign mag_a       = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b       = b_q[WIDTH-1] ? -b_q : b_q;
  assign prod_next   = prod + (mplier[0] ? mcand : '0);
  assign prod_signed = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -prod_next : prod_next;
  assign mul_y       = prod_signed[WIDTH-1:0];
  assign mul_ovf     = prod_signed != {{WIDTH{mul_y[WIDTH-1]}}, mul_y};

  always_comb begin
    fin_y   = '0;
    fin_ovf = 1'b0;
    if (state == S_MUL) begin
      fin_y   = mul_y;
      fin_ovf = mul_ovf;
    end else begin
      case (op_q)
        OP_ADD: begin fin_y = add_y; fin_ovf = add_ovf; end
        OP_SUB: begin fin_y = sub_y; fin_ovf = sub_ovf; end
        OP_AND: fin_y = a_q & b_q;
        OP_OR:  fin_y = a_q | b_q;
        OP_ACC: begin fin_y = acc_y; fin_ovf = acc_ovf; end
        default: ;
      endcase
    end
  end

  assign fin_mag = fin_y[WIDTH-1] ? -fin_y : fin_y;
  assign mag_ext = {{(17-WIDTH){1'b0}}, fin_mag};

  seg7_enc u_seg7_enc (
    .mag  (mag_ext[3:0]),
    .neg  (fin_y[WIDTH-1]),
    .fits (mag_ext <= 17'd15),
    .ovf  (fin_ovf),
    .seg  (seg_next)
  );

  always_ff @(posedge clk_2) begin
    // NOTE: state flops use non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      y      <= '0;
      ovf    <= 1'b0;
      acc    <= '0;
      seg    <= {1'b0, SEG_0};
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          state <= S_EXEC;
        end
        S_EXEC: begin
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          prod   <= '0;
          cnt    <= '0;
          if (op_q == OP_MUL && MUL_EN != 0) begin
            state <= S_MUL;
          end else begin
            state <= S_DONE;
            y     <= fin_y;
            ovf   <= fin_ovf;
            seg   <= seg_next;
            if (op_q == OP_ACC) acc <= acc_y;
          end
        end
        S_MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_DONE;
            y     <= fin_y;
            ovf   <= fin_ovf;
            seg   <= seg_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_alu_7seg.md
SEQ_ALU_7SEG -- requirements
Module: seq_alu_7seg

Interface
REQ-001 Parameter: WIDTH, 8, signed operand/result width; legal range 3..16.
REQ-002 Parameter: MUL_EN, 1, 1 = iterative multiply enabled; 0 = MUL decodes as invalid op.
REQ-003 Port: clk_2  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: start  in  1  request; accepted only in IDLE.
REQ-006 Port: op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 ACC, 110/111 invalid.
REQ-007 Port: a, b  in  WIDTH each  signed two's-complement operands.
REQ-008 Port: busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-009 Port: done  out  1  one-cycle pulse; y, ovf and seg are valid in that cycle.
REQ-010 Port: y  out  WIDTH  signed registered result.
REQ-011 Port: ovf  out  1  registered overflow flag for the last completed op.
REQ-012 Port: acc  out  WIDTH  signed accumulator.
REQ-013 Port: seg  out  8  registered 7-segment pattern: bits 6:0 = gfedcba; bit 7 = minus sign.

Function
REQ-014 FSM states: IDLE, EXEC, MUL, DONE.
REQ-015 Transitions: IDLE->EXEC on start, latching op, a and b; EXEC->MUL if op=MUL and MUL_EN=1, otherwise EXEC->DONE; MUL->DONE after exactly WIDTH MUL cycles; DONE->IDLE unconditionally.
REQ-016 start outside IDLE is ignored, including in the DONE cycle; latched operands never change mid-operation.
REQ-017 Latency, counted from the cycle start is sampled (cycle 0): done in cycle 2 for non-MUL ops; done in cycle WIDTH+2 for MUL.
REQ-018 ADD/SUB: result wraps modulo 2^WIDTH; ovf=1 when the true result falls outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 AND/OR: bitwise on the latched operands; ovf=0.
REQ-020 MUL: shift-add on operand magnitudes for WIDTH cycles into a 2*WIDTH product, negated when the operand signs differ; y = low WIDTH bits; ovf=1 when the 2*WIDTH product is not the sign-extension of y.
REQ-021 ACC: acc <= acc + a (wraps); y = new acc value; ovf as ADD; b is ignored; acc is unchanged by every other op.
REQ-022 Invalid op: y=0, ovf=0, acc unchanged; done still pulses with normal latency.
REQ-023 y, ovf and seg update only on entry to DONE and hold until the next completion.
REQ-024 seg encoding, priority order:
  - ovf=1: 8'h00 (blank).
  - |y|<=15: hex digit of |y| (0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71), bit 7 = sign of y.
  - otherwise: 8'h40 (dash).
REQ-025 y=-2^(WIDTH-1) with WIDTH<=4 displays its magnitude digit with bit 7 set (e.g. -4 -> 8'hE6).

Reset
REQ-026 reset has priority over all other inputs, aborts any operation and forces state IDLE.
REQ-027 Reset values: busy=0, done=0, y=0, ovf=0, acc=0, seg=8'h3F, MUL counter and product=0.
REQ-028 A reset during EXEC or MUL produces no done pulse.

Structure
REQ-029 Package seq_alu_pkg SHALL hold: op enum, state enum, 16 digit segment constants, BLANK, DASH, MINUS_BIT.
REQ-030 Sub-module seg7_enc SHALL map a 4-bit magnitude, sign and ovf to the 8-bit pattern (combinational); its output is registered in seq_alu_7seg.

Verification
REQ-031 WIDTH=8, ADD a=100 b=50 -> done in cycle 2, y=-106, ovf=1, seg=8'h00.
REQ-032 SUB a=3 b=5 -> y=-2, ovf=0, seg=8'hDB; a second start during busy is ignored (exactly one done pulse).
REQ-033 MUL a=-7 b=6 -> done in cycle 10, y=-42, ovf=0, seg=8'h40; MUL a=-128 b=-128 -> y=0, ovf=1.
REQ-034 After reset, ACC a=5 three times -> acc=15, seg=8'h71; then ACC a=120 -> acc=-121, ovf=1.
REQ-035 reset asserted in MUL cycle 3 -> next cycle busy=0, y=0, acc=0, seg=8'h3F, no done pulse.
REQ-036 op=111 -> done in cycle 2, y=0, ovf=0, seg=8'h3F; with MUL_EN=0, op=100 behaves the same.
